// File: rtl/memory_pkg.sv
// memory_pkg
// Shared definitions for the behavioural main-memory responder and the
// bus models that reuse its latency timer.
//   - mem_state_e        : responder FSM state encoding
//   - mem_select_latency : picks the access latency from the open-row result
package memory_pkg;

    localparam int MEM_STATE_BITS = 2;

    typedef enum logic [MEM_STATE_BITS-1:0] {
        MEM_STATE_IDLE       = 2'd0,
        MEM_STATE_READ_WAIT  = 2'd1,
        MEM_STATE_WRITE_WAIT = 2'd2
    } mem_state_e;

    // A request that lands in the currently open row takes the short path.
    function automatic int unsigned mem_select_latency(
        input logic        row_hit,
        input int unsigned latency,
        input int unsigned row_hit_latency
    );
        return row_hit ? row_hit_latency : latency;
    endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// mem_latency_timer
// Loadable down-counter used to model access latency.
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset, clears the count
//   load       in  : load load_value this cycle (takes priority over counting)
//   load_value in  : count to load
//   expired    out : high while the count is zero
module mem_latency_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Behavioural main memory at the bottom of the cache miss path. Accepts one
// single-word read or write at a time, holds ready low for a row-miss or
// row-hit latency, then completes the access.
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous active-high reset
//   addr  in  : request word address (bits above DEPTH_BITS ignored)
//   din   in  : write data
//   dout  out : read data, held until the next read completes
//   re    in  : read request pulse (sampled only while ready)
//   we    in  : write request pulse (wins over re)
//   ready out : idle / last access complete
module memory_responder
    import memory_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 64,
    parameter int          WORD_WIDTH      = 64,
    parameter int          DEPTH_BITS      = 10,
    parameter int          COL_BITS        = 3,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned ROW_HIT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam int ROW_W = DEPTH_BITS - COL_BITS;

    mem_state_e state, next_state;

    logic [WORD_WIDTH-1:0] mem [2**DEPTH_BITS];

    logic [DEPTH_BITS-1:0] lat_idx;
    logic [WORD_WIDTH-1:0] lat_din;
    logic                  row_valid;
    logic [ROW_W-1:0]      open_row;

    logic [DEPTH_BITS-1:0] req_idx;
    logic [ROW_W-1:0]      req_row;
    logic                  row_hit;
    logic                  accept;
    logic                  expired;
    logic [CNT_W-1:0]      load_value;

    // Upper address bits only matter to the wider system; the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:DEPTH_BITS];

    assign req_idx = addr[DEPTH_BITS-1:0];
    assign req_row = addr[DEPTH_BITS-1:COL_BITS];
    assign row_hit = row_valid && (open_row == req_row);

    // The timer expires on the cycle before the completion edge, so it is
    // loaded with one less than the number of cycles ready stays low.
    assign load_value = CNT_W'(mem_select_latency(row_hit, LATENCY, ROW_HIT_LATENCY) - 1);

    mem_latency_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_value(load_value),
        .expired   (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are only looked at in IDLE; anything arriving while waiting
    // is dropped rather than queued. Write wins when both pulses are high.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ready      = 1'b0;
        case (state)
            MEM_STATE_IDLE: begin
                ready = 1'b1;
                if (we) begin
                    accept     = 1'b1;
                    next_state = MEM_STATE_WRITE_WAIT;
                end else if (re) begin
                    accept     = 1'b1;
                    next_state = MEM_STATE_READ_WAIT;
                end
            end
            MEM_STATE_READ_WAIT,
            MEM_STATE_WRITE_WAIT: begin
                if (expired) begin
                    next_state = MEM_STATE_IDLE;
                end
            end
            default: begin
                next_state = MEM_STATE_IDLE;
            end
        endcase
    end

    // Request capture and open-row tracking. Every accepted access opens
    // its row, whether it was a hit or a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_idx   <= '0;
            lat_din   <= '0;
            row_valid <= 1'b0;
            open_row  <= '0;
        end else if (accept) begin
            lat_idx   <= req_idx;
            lat_din   <= din;
            row_valid <= 1'b1;
            open_row  <= req_row;
        end
    end

    // Read data is only updated when a read completes, so writes (even to
    // the last address read) leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if ((state == MEM_STATE_READ_WAIT) && expired) begin
            dout <= mem[lat_idx];
        end
    end

    // Storage is not reset. A write commits only at its completion edge, so
    // a reset during WRITE_WAIT drops it.
    always_ff @(posedge clk) begin
        if ((state == MEM_STATE_WRITE_WAIT) && expired) begin
            mem[lat_idx] <= lat_din;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Directed bench for memory_responder with default parameters
// (DEPTH_BITS=10, COL_BITS=3, LATENCY=4, ROW_HIT_LATENCY=1).
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        ready;

    always #5 clk = ~clk;

    memory_responder dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .re   (re),
        .we   (we),
        .ready(ready)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    // Reference model: word-level memory, open row, and the cycle at which
    // the current access is due to complete.
    logic [63:0] model_mem [int];
    bit          m_row_valid = 1'b0;
    int          m_open_row = 0;
    int          done_at = 0;
    logic [63:0] dout_before = '0;
    logic [63:0] dout_after = '0;
    bit          pend_w = 1'b0;
    int          pend_idx = 0;
    logic [63:0] pend_data = '0;

    // Observed ready-low run length and completion count.
    int low_cnt = 0;
    int last_low = 0;
    int rises = 0;
    bit prev_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model_read(input int idx);
        return model_mem.exists(idx) ? model_mem[idx] : 64'h0;
    endfunction

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, plus latency observation.
    always @(negedge clk) begin
        if (check_en) begin
            logic exp_ready;
            exp_ready = (cyc >= done_at);
            check_value("ready", {63'b0, ready}, {63'b0, exp_ready});
            check_value("dout", dout, exp_ready ? dout_after : dout_before);
            if (!ready) begin
                low_cnt++;
            end else if (!prev_ready) begin
                last_low = low_cnt;
                rises++;
                low_cnt = 0;
            end
            prev_ready = ready;
        end
    end

    // Drives one request pulse sampled at the next rising edge and tells the
    // model about it. Only called while the model says the DUT is idle.
    task automatic apply_stimulus(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        int idx;
        int row;
        int lat;
        @(negedge clk);
        #1;
        re = r;
        we = w;
        addr = a;
        din = d;
        if (pend_w) model_mem[pend_idx] = pend_data;
        pend_w = 1'b0;
        idx = int'(a[9:0]);
        row = idx >> 3;
        lat = (m_row_valid && row == m_open_row) ? 1 : 4;
        m_row_valid = 1'b1;
        m_open_row = row;
        dout_before = dout_after;
        done_at = cyc + 1 + lat;
        if (w) begin
            pend_w = 1'b1;
            pend_idx = idx;
            pend_data = d;
        end else begin
            dout_after = model_read(idx);
        end
        @(posedge clk);
        #1;
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc < done_at) @(negedge clk);
        #2;
    endtask

    task automatic check_output(input string name, input int exp_low, input logic [63:0] exp_dout);
        wait_done();
        check_value({name, " latency"}, 64'(last_low), 64'(exp_low));
        check_value({name, " dout"}, dout, exp_dout);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_value("reset ready", {63'b0, ready}, 64'h1);
        check_value("reset dout", dout, 64'h0);
        done_at = cyc;
        dout_before = '0;
        dout_after = '0;
        m_row_valid = 1'b0;
        pend_w = 1'b0;
        low_cnt = 0;
        prev_ready = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rises_before;
        #2;
        rst = 1'b1;
        #1;
        check_value("power-up ready", {63'b0, ready}, 64'h1);
        check_value("power-up dout", dout, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        done_at = cyc;
        check_en = 1'b1;

        apply_stimulus(1, 0, 64'h0, 0);
        check_output("read 0 after reset", 4, 64'h0);

        apply_stimulus(0, 1, 64'h8, 64'hDEAD);
        check_output("write 8", 4, 64'h0);

        apply_stimulus(1, 0, 64'h8, 0);
        check_output("read 8 row hit", 1, 64'hDEAD);

        apply_stimulus(1, 1, 64'h3, 64'h55);
        check_output("re+we addr 3", 4, 64'hDEAD);

        apply_stimulus(1, 0, 64'h3, 0);
        check_output("read 3", 1, 64'h55);

        apply_stimulus(0, 1, 64'h3, 64'h99);
        check_output("write last-read addr", 1, 64'h55);

        apply_stimulus(1, 0, 64'h9, 0);
        check_output("read 9 row miss", 4, 64'h0);

        apply_stimulus(1, 0, 64'h10, 0);
        check_output("read 0x10 row miss", 4, 64'h0);

        // Extra read pulse while the DUT is busy must be ignored.
        rises_before = rises;
        apply_stimulus(1, 0, 64'h18, 0);
        @(negedge clk);
        #1;
        re = 1'b1;
        addr = 64'h8;
        @(posedge clk);
        #1;
        re = 1'b0;
        check_output("read 0x18 with busy pulse", 4, 64'h0);
        repeat (3) @(negedge clk);
        #2;
        check_value("single completion", 64'(rises - rises_before), 64'h1);

        apply_stimulus(0, 1, 64'h400, 64'h77);
        check_output("write 0x400 wrap", 4, 64'h0);

        apply_stimulus(1, 0, 64'h0, 0);
        check_output("read 0 after wrap write", 1, 64'h77);

        // Reset while a write to address 5 is in flight.
        apply_stimulus(1, 0, 64'h20, 0);
        check_output("read 0x20", 4, 64'h0);
        apply_stimulus(0, 1, 64'h5, 64'hAB);
        check_value("busy before reset", {63'b0, ready}, 64'h0);
        do_reset();

        apply_stimulus(1, 0, 64'h5, 0);
        check_output("read 5 after aborted write", 4, 64'h0);

        apply_stimulus(1, 0, 64'h3, 0);
        check_output("read 3 row hit", 1, 64'h99);

        repeat (2) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
